// File: rtl/loteria_entrada_if.sv
// Keypad-side and checker-side signal bundle of the ticket-entry sequencer.
// master: keypad/checker environment; slave: loteria_entrada.
interface loteria_entrada_if;
  logic [3:0] tecla;
  logic       tecla_valida;
  logic       confirma;
  logic       cancela;
  logic [3:0] numero;
  logic       insere;
  logic       fim_jogo;
  logic       fim;
  logic [2:0] jogos;
  logic       ocupado;
  logic       erro;

  modport master (
    output tecla, tecla_valida, confirma, cancela,
    input  numero, insere, fim_jogo, fim, jogos, ocupado, erro
  );

  modport slave (
    input  tecla, tecla_valida, confirma, cancela,
    output numero, insere, fim_jogo, fim, jogos, ocupado, erro
  );
endinterface

// File: rtl/loteria_entrada.sv
// Ticket-entry sequencer: buffers keypad digits, replays them to the lottery checker.
// Optional: define LOTERIA_CHECA_DIGITO_EN to reject keypad values 10..15.
module loteria_entrada #(
  parameter int DIGITOS   = 5,
  parameter int MAX_JOGOS = 5,
  parameter int GAP       = 1
) (
  input  logic               clock,
  input  logic               reset,
  loteria_entrada_if.slave   bus_io
);

  localparam int IDX_W = $clog2(DIGITOS + 1);
  localparam int BUF_N = 1 << IDX_W;
  localparam logic [IDX_W-1:0] ULTIMO    = IDX_W'(DIGITOS);
  localparam logic [1:0]       GAP_FIM   = 2'(GAP - 1);
  localparam logic [2:0]       JOGOS_MAX = 3'(MAX_JOGOS);
  localparam bit               TEM_GAP   = (GAP > 0);

  typedef enum logic [2:0] {
    COLETA    = 3'd0,
    ENVIA     = 3'd1,
    INTERVALO = 3'd2,
    FECHA     = 3'd3,
    ENCERRADO = 3'd4
  } estado_t;

  estado_t          estado_q, estado_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [1:0]       gap_cnt_q, gap_cnt_d;
  logic [2:0]       jogos_q, jogos_d;
  logic [3:0]       numero_q, numero_d;
  logic             insere_q, insere_d;
  logic             fim_jogo_q, fim_jogo_d;
  logic             fim_q, fim_d;
  logic             ocupado_q, ocupado_d;
  logic             erro_q, erro_d;

  logic [3:0]       buf_q [BUF_N];
  logic             buf_we_s;
  logic             strobe_s;
  logic             digito_ilegal_s;

  assign strobe_s = bus_io.tecla_valida | bus_io.confirma | bus_io.cancela;

`ifdef LOTERIA_CHECA_DIGITO_EN
  assign digito_ilegal_s = (bus_io.tecla > 4'd9);
`else
  assign digito_ilegal_s = 1'b0;
`endif

  // Next-state, buffer pointers and registered-output next values
  always_comb begin
    estado_d  = estado_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    gap_cnt_d = gap_cnt_q;
    jogos_d   = jogos_q;
    numero_d  = numero_q;
    erro_d    = 1'b0;
    buf_we_s  = 1'b0;

    case (estado_q)
      COLETA: begin
        if (bus_io.cancela) begin
          wr_idx_d = '0;
        end else if (bus_io.confirma) begin
          if (wr_idx_q == ULTIMO) begin
            estado_d = ENVIA;
            rd_idx_d = '0;
          end else begin
            erro_d = 1'b1;
          end
        end else if (bus_io.tecla_valida) begin
          if ((wr_idx_q != ULTIMO) && !digito_ilegal_s) begin
            buf_we_s = 1'b1;
            wr_idx_d = wr_idx_q + IDX_W'(1);
          end else begin
            erro_d = 1'b1;
          end
        end else begin
          estado_d = COLETA;
        end
      end
      ENVIA: begin
        erro_d = strobe_s;
        if (TEM_GAP) begin
          estado_d  = INTERVALO;
          gap_cnt_d = 2'd0;
        end else if (rd_idx_q == ULTIMO) begin
          estado_d = FECHA;
        end else begin
          estado_d = ENVIA;
        end
      end
      INTERVALO: begin
        erro_d = strobe_s;
        if (gap_cnt_q == GAP_FIM) begin
          if (rd_idx_q == ULTIMO) begin
            estado_d = FECHA;
          end else begin
            estado_d = ENVIA;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 2'd1;
        end
      end
      FECHA: begin
        erro_d   = strobe_s;
        wr_idx_d = '0;
        if (jogos_q == JOGOS_MAX) begin
          estado_d = ENCERRADO;
        end else begin
          estado_d = COLETA;
        end
      end
      ENCERRADO: begin
        estado_d = ENCERRADO;
      end
      default: begin
        estado_d = COLETA;
      end
    endcase

    // Digits are fetched on entry to ENVIA so numero/insere leave a register together
    if (estado_d == ENVIA) begin
      numero_d = buf_q[rd_idx_d];
      rd_idx_d = rd_idx_d + IDX_W'(1);
    end else begin
      numero_d = numero_d;
    end

    if (estado_d == FECHA) begin
      jogos_d = jogos_q + 3'd1;
    end else begin
      jogos_d = jogos_d;
    end
  end

  assign insere_d   = (estado_d == ENVIA);
  assign fim_jogo_d = (estado_d == FECHA);
  assign fim_d      = (estado_d == ENCERRADO);
  assign ocupado_d  = (estado_d == ENVIA) || (estado_d == INTERVALO) || (estado_d == FECHA);

  // State, pointers and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= COLETA;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      gap_cnt_q  <= 2'd0;
      jogos_q    <= 3'd0;
      numero_q   <= 4'd0;
      insere_q   <= 1'b0;
      fim_jogo_q <= 1'b0;
      fim_q      <= 1'b0;
      ocupado_q  <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      gap_cnt_q  <= gap_cnt_d;
      jogos_q    <= jogos_d;
      numero_q   <= numero_d;
      insere_q   <= insere_d;
      fim_jogo_q <= fim_jogo_d;
      fim_q      <= fim_d;
      ocupado_q  <= ocupado_d;
      erro_q     <= erro_d;
    end
  end

  // Ticket storage; contents are don't-care until written, so no reset
  always_ff @(posedge clock) begin
    if (buf_we_s) begin
      buf_q[wr_idx_q] <= bus_io.tecla;
    end
  end

  assign bus_io.numero   = numero_q;
  assign bus_io.insere   = insere_q;
  assign bus_io.fim_jogo = fim_jogo_q;
  assign bus_io.fim      = fim_q;
  assign bus_io.jogos    = jogos_q;
  assign bus_io.ocupado  = ocupado_q;
  assign bus_io.erro     = erro_q;

endmodule

// File: tb/tb_loteria_entrada.sv
// Directed bench for loteria_entrada (DIGITOS=5, MAX_JOGOS=5, GAP=1).
module tb_loteria_entrada;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

`ifdef LOTERIA_CHECA_DIGITO_EN
  localparam bit CHECA = 1'b1;
`else
  localparam bit CHECA = 1'b0;
`endif

  loteria_entrada_if bus ();

  loteria_entrada #(
    .DIGITOS   (5),
    .MAX_JOGOS (5),
    .GAP       (1)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .bus_io (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] tecla;
    logic       tv;
    logic       cf;
    logic       cn;
    logic       ins;
    logic [3:0] num;
    logic       err;
    logic       fj;
    logic       ocp;
    logic [2:0] jog;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle(input logic [3:0] t, input logic tv, input logic cf, input logic cn);
    @(negedge clock);
    bus.tecla        = t;
    bus.tecla_valida = tv;
    bus.confirma     = cf;
    bus.cancela      = cn;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [19:0] pack5(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] c, input logic [3:0] d,
                                        input logic [3:0] e);
    return {e, d, c, b, a};
  endfunction

  task automatic keys(input logic [19:0] digs);
    for (int k = 0; k < 5; k++) begin
      cycle(digs[4*k +: 4], 1'b1, 1'b0, 1'b0);
      chk("key_erro", int'(bus.erro), 0);
    end
  endtask

  // confirma, then collect the replay until fim_jogo within a cycle budget
  task automatic play(input logic [19:0] digs, input int exp_jogos);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    cycle(4'd0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 40 && !seen; c++) begin
      if (c > 0) cycle(4'd0, 1'b0, 1'b0, 1'b0);
      if (bus.insere) begin
        if (n < 5) chk("replay_numero", int'(bus.numero), int'(digs[4*n +: 4]));
        n++;
      end
      if (bus.fim_jogo) begin
        seen = 1'b1;
        chk("replay_jogos", int'(bus.jogos), exp_jogos);
      end
    end
    chk("replay_insere_count", n, 5);
    chk("replay_fim_jogo_seen", int'(seen), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    errors = 0;
    checks = 0;
    bus.tecla        = 4'd0;
    bus.tecla_valida = 1'b0;
    bus.confirma     = 1'b0;
    bus.cancela      = 1'b0;
    reset            = 1'b1;

    //            tecla tv    cf    cn    ins   num   err   fj    ocp   jog
    tbl[0]  = '{4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0};
    tbl[1]  = '{4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0};
    tbl[2]  = '{4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0};
    tbl[3]  = '{4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0};
    tbl[4]  = '{4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0};
    tbl[5]  = '{4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 3'd0};
    tbl[6]  = '{4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1, 3'd0};
    tbl[7]  = '{4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 3'd0};
    tbl[8]  = '{4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b1, 3'd0};
    tbl[9]  = '{4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b1, 3'd0};
    tbl[10] = '{4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 1'b1, 3'd0};
    tbl[11] = '{4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 3'd0};
    tbl[12] = '{4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 3'd0};
    tbl[13] = '{4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 3'd0};
    tbl[14] = '{4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 3'd0};
    tbl[15] = '{4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 3'd1};
    tbl[16] = '{4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 3'd1};
    tbl[17] = '{4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd1};

    repeat (2) @(posedge clock);
    #1;
    chk("rst_numero",   int'(bus.numero),   0);
    chk("rst_insere",   int'(bus.insere),   0);
    chk("rst_fim_jogo", int'(bus.fim_jogo), 0);
    chk("rst_fim",      int'(bus.fim),      0);
    chk("rst_jogos",    int'(bus.jogos),    0);
    chk("rst_ocupado",  int'(bus.ocupado),  0);
    chk("rst_erro",     int'(bus.erro),     0);
    @(negedge clock);
    reset = 1'b0;

    // Ticket 1, cycle by cycle: busy cancela, then a key during FECHA
    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].tecla, tbl[i].tv, tbl[i].cf, tbl[i].cn);
      chk($sformatf("tbl%0d_insere", i),   int'(bus.insere),   int'(tbl[i].ins));
      chk($sformatf("tbl%0d_numero", i),   int'(bus.numero),   int'(tbl[i].num));
      chk($sformatf("tbl%0d_erro", i),     int'(bus.erro),     int'(tbl[i].err));
      chk($sformatf("tbl%0d_fim_jogo", i), int'(bus.fim_jogo), int'(tbl[i].fj));
      chk($sformatf("tbl%0d_ocupado", i),  int'(bus.ocupado),  int'(tbl[i].ocp));
      chk($sformatf("tbl%0d_jogos", i),    int'(bus.jogos),    int'(tbl[i].jog));
      chk($sformatf("tbl%0d_fim", i),      int'(bus.fim),      0);
    end

    // Premature confirma, then cancela winning over confirma and tecla
    cycle(4'd5, 1'b1, 1'b0, 1'b0);
    cycle(4'd3, 1'b1, 1'b0, 1'b0);
    cycle(4'd0, 1'b0, 1'b1, 1'b0);
    chk("early_confirma_erro",   int'(bus.erro),   1);
    chk("early_confirma_insere", int'(bus.insere), 0);
    cycle(4'd1, 1'b1, 1'b1, 1'b1);
    chk("cancela_prio_erro", int'(bus.erro), 0);
    keys(pack5(4'd9, 4'd9, 4'd9, 4'd9, 4'd9));
    play(pack5(4'd9, 4'd9, 4'd9, 4'd9, 4'd9), 2);
    cycle(4'd0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between the 2nd and 3rd insere
    keys(pack5(4'd1, 4'd2, 4'd3, 4'd4, 4'd5));
    cycle(4'd0, 1'b0, 1'b1, 1'b0);
    chk("rstmid_first_insere", int'(bus.insere), 1);
    n = bus.insere ? 1 : 0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      cycle(4'd0, 1'b0, 1'b0, 1'b0);
      if (bus.insere) n++;
    end
    chk("rstmid_second_insere", n, 2);
    #1;
    reset = 1'b1;
    #1;
    chk("rstmid_insere",  int'(bus.insere),  0);
    chk("rstmid_ocupado", int'(bus.ocupado), 0);
    chk("rstmid_jogos",   int'(bus.jogos),   0);
    chk("rstmid_numero",  int'(bus.numero),  0);
    @(negedge clock);
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      cycle(4'd0, 1'b0, 1'b0, 1'b0);
      if (bus.insere || bus.fim_jogo || bus.ocupado) bad++;
    end
    chk("rstmid_no_activity", bad, 0);

    // Sixth key rejected; replay keeps the first five
    keys(pack5(4'd1, 4'd2, 4'd3, 4'd4, 4'd5));
    cycle(4'd6, 1'b1, 1'b0, 1'b0);
    chk("sixth_key_erro", int'(bus.erro), 1);
    play(pack5(4'd1, 4'd2, 4'd3, 4'd4, 4'd5), 1);
    cycle(4'd0, 1'b0, 1'b0, 1'b0);

    // Keypad value 12
    cycle(4'd12, 1'b1, 1'b0, 1'b0);
    chk("tecla12_erro", int'(bus.erro), int'(CHECA));
    cycle(4'd4, 1'b1, 1'b0, 1'b0);
    cycle(4'd5, 1'b1, 1'b0, 1'b0);
    cycle(4'd6, 1'b1, 1'b0, 1'b0);
    cycle(4'd7, 1'b1, 1'b0, 1'b0);
    if (CHECA) cycle(4'd8, 1'b1, 1'b0, 1'b0);
    play(CHECA ? pack5(4'd4, 4'd5, 4'd6, 4'd7, 4'd8)
               : pack5(4'd12, 4'd4, 4'd5, 4'd6, 4'd7), 2);
    cycle(4'd0, 1'b0, 1'b0, 1'b0);

    // Remaining tickets up to the session limit
    for (int t = 3; t <= 5; t++) begin
      keys(pack5(4'(t), 4'(t), 4'(t), 4'(t), 4'(t)));
      play(pack5(4'(t), 4'(t), 4'(t), 4'(t), 4'(t)), t);
      chk("session_fim_during_fecha", int'(bus.fim), 0);
      cycle(4'd0, 1'b0, 1'b0, 1'b0);
    end
    chk("end_fim",     int'(bus.fim),     1);
    chk("end_ocupado", int'(bus.ocupado), 0);
    chk("end_jogos",   int'(bus.jogos),   5);

    // Closed session ignores everything
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 1) cycle(4'(i), 1'b1, 1'b0, 1'b0);
      else            cycle(4'd0, 1'b0, 1'b1, 1'b0);
      chk("closed_insere", int'(bus.insere), 0);
      chk("closed_erro",   int'(bus.erro),   0);
      chk("closed_fim",    int'(bus.fim),    1);
      chk("closed_jogos",  int'(bus.jogos),  5);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/loteria_entrada.md
# loteria_entrada

Ticket-entry sequencer placed directly upstream of the lottery checker FSM. It collects keypad digits into a DIGITOS-deep buffer and, on confirmation, replays the buffered ticket to the checker as `numero` values with single-cycle `insere` strobes. It closes the game with a `fim_jogo` pulse and asserts `fim` once MAX_JOGOS tickets have been played.

## Interface
- DIGITOS, 5, digits per ticket (2..8)
- MAX_JOGOS, 5, tickets per session (1..7)
- GAP, 1, idle cycles between consecutive `insere` pulses (0..3)

- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- tecla  in  4  keypad digit
- tecla_valida  in  1  one-cycle strobe; `tecla` valid
- confirma  in  1  one-cycle strobe; submit buffered ticket
- cancela  in  1  one-cycle strobe; discard buffered digits
- numero  out  4  digit presented to checker
- insere  out  1  one-cycle strobe; `numero` valid
- fim_jogo  out  1  one-cycle pulse; ticket fully sent
- fim  out  1  level; session finished
- jogos  out  3  tickets sent so far
- ocupado  out  1  high in ENVIA/INTERVALO/FECHA
- erro  out  1  one-cycle pulse; request rejected

## Operation
- States: COLETA, ENVIA, INTERVALO, FECHA, ENCERRADO. Reset → COLETA.
- Reset values: numero=0, insere=0, fim_jogo=0, fim=0, jogos=0, ocupado=0, erro=0; wr_idx=0, rd_idx=0, gap counter=0. Buffer contents undefined.
- COLETA, input priority per cycle: cancela > confirma > tecla_valida; lower-priority strobes in the same cycle are dropped without erro.
  - cancela: wr_idx←0.
  - confirma with wr_idx==DIGITOS: → ENVIA, rd_idx←0. With wr_idx<DIGITOS: erro pulse, stay.
  - tecla_valida with wr_idx<DIGITOS (and digit legal, see Configuration): buf[wr_idx]←tecla, wr_idx+1. With wr_idx==DIGITOS: erro pulse, buffer unchanged.
- ENVIA (1 cycle): insere=1, numero=buf[rd_idx]; rd_idx+1. If GAP>0 → INTERVALO, else → ENVIA for the next digit. After digit DIGITOS-1: → INTERVALO if GAP>0, else → FECHA.
- INTERVALO: insere=0, numero holds last value; lasts GAP cycles, then → ENVIA, or → FECHA if all digits sent.
- FECHA (1 cycle): fim_jogo=1, jogos←jogos+1, wr_idx←0. → ENCERRADO if the new jogos==MAX_JOGOS, else → COLETA.
- ENCERRADO: fim=1, ocupado=0; all strobes ignored, erro stays 0; left only by reset.
- In ENVIA/INTERVALO/FECHA, any tecla_valida/confirma/cancela produces an erro pulse and is otherwise ignored.
- No wrap-around: jogos saturates at MAX_JOGOS by construction.

## Timing
- All outputs registered; erro is asserted the cycle after the offending strobe.
- confirma accepted at edge T: first insere at T+1; digit k at T+1+k·(GAP+1); fim_jogo at T+1+DIGITOS·(GAP+1) with the default GAP≥1 (at T+1+DIGITOS when GAP=0); jogos updated on the same cycle fim_jogo is high.
- First tecla_valida is accepted in the cycle after fim_jogo.
- fim rises in the cycle after the final fim_jogo.
- Asynchronous reset mid-ticket: outputs return to reset values immediately; partial ticket is lost and no fim_jogo is issued.

## Configuration
- `LOTERIA_CHECA_DIGITO_EN` defined: tecla values 10..15 are rejected with an erro pulse and are not stored.
- Undefined: all 16 tecla values are stored; erro is produced only by full-buffer, premature-confirma and busy conditions.

## Test plan
- Keys 5,3,8,2,0 then confirma (GAP=1) → insere at T+1,3,5,7,9 with numero 5,3,8,2,0; fim_jogo at T+11; jogos=1.
- Keys 5,3 then confirma → erro pulse, no insere; then cancela and keys 9,9,9,9,9 plus confirma → sequence 9×5.
- Sixth key after 5 digits → erro pulse; buffer still replays the first 5 digits.
- Five complete tickets → jogos=5, fim=1 after 5th fim_jogo; further confirma/tecla produce no insere and no erro.
- tecla=12 with macro defined → erro, wr_idx unchanged; without macro → stored, replayed as numero=12.
- reset asserted between the 2nd and 3rd insere → insere=0, ocupado=0, jogos=0 immediately; no fim_jogo follows.
